// File: rtl/dcache_wb_axi.sv
// dcache_wb_axi: write-back buffer plus AXI write master for the data cache.
// Evicted dirty lines are queued in a DEPTH-entry FIFO. Each entry is drained
// as one INCR burst of LINE_WORDS 32-bit beats. An entry is popped only after
// its B response, so a refill probe (q_addr/q_hit) still sees the line while
// its burst is in flight.
// Ports:
//   clk, rst                     clock, async active-high reset
//   wb_req/wb_addr/wb_data       line push from dcache; wb_ready = FIFO not full
//   q_addr/q_hit                 combinational line-address probe of valid entries
//   wb_empty                     nothing queued and master idle
//   wb_err                       sticky, set by any non-OKAY B response
//   aw*/w*/b*                    AXI write address / data / response channels
module dcache_wb_axi #(
  parameter int         LINE_WORDS = 8,
  parameter int         DEPTH      = 2,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_req,
  input  logic [31:0]              wb_addr,
  input  logic [LINE_WORDS*32-1:0] wb_data,
  output logic                     wb_ready,
  input  logic [31:0]              q_addr,
  output logic                     q_hit,
  output logic                     wb_empty,
  output logic                     wb_err,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);
  localparam int OFF_W  = $clog2(LINE_WORDS*4);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS*32;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t            state;
  logic [31:0]       addr_mem [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [BEAT_W-1:0] beat;
  logic [LINE_W-1:0] head_line;
  logic              push, pop;
  logic              unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign wb_ready = (count != CNT_W'(DEPTH));
  assign push     = wb_req & wb_ready;
  assign pop      = (state == S_B) & bvalid;
  assign wb_empty = (count == '0) && (state == S_IDLE);

  // Offset bits are dropped on entry so the stored address is the bus address.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= {wb_addr[31:OFF_W], {OFF_W{1'b0}}};
      data_mem[tail] <= wb_data;
    end
  end

  // Handshake decodes come only from registered state/beat, never from
  // the slave's ready/valid inputs.
  assign awvalid   = (state == S_AW);
  assign wvalid    = (state == S_W);
  assign bready    = (state == S_B);
  assign wlast     = wvalid && (beat == BEAT_W'(LINE_WORDS-1));
  assign head_line = data_mem[head];
  assign awaddr    = addr_mem[head];
  assign wdata     = head_line[32*beat +: 32];

  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign awlen   = 8'(LINE_WORDS-1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'b000;
  assign wstrb   = 4'hf;

  // A push and a pop never target the same slot: a pop needs count>0 and a
  // push needs count<DEPTH, so head != tail whenever both happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      vld    <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      beat   <= '0;
      wb_err <= 1'b0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= ptr_inc(head);
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      case (state)
        S_IDLE: if (count != '0) state <= S_AW;
        S_AW:   if (awready) state <= S_W;
        S_W: if (wready) begin
          if (wlast) begin
            beat  <= '0;
            state <= S_B;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_B: if (bvalid) begin
          state <= S_IDLE;
          if (bresp != 2'b00) wb_err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && (addr_mem[i][31:OFF_W] == q_addr[31:OFF_W])) q_hit = 1'b1;
  end

  assign unused_bits = ^{bid, wb_addr[OFF_W-1:0], q_addr[OFF_W-1:0]};
endmodule

// File: tb/tb_dcache_wb_axi.sv
module tb_dcache_wb_axi;
  localparam int LW = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic wb_req = 1'b0;
  logic [31:0] wb_addr = '0, q_addr = '0;
  logic [LW*32-1:0] wb_data = '0;
  logic wb_ready, q_hit, wb_empty, wb_err;
  logic [3:0] awid, awcache, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst, awlock, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  dcache_wb_axi #(.LINE_WORDS(LW), .DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .q_addr(q_addr), .q_hit(q_hit), .wb_empty(wb_empty),
    .wb_err(wb_err), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready));

  int errors = 0, checks = 0, cyc = 0;

  // Observed traffic (monitor) and reference model of queued lines.
  logic [31:0] aw_q[$], wd_q[$];
  logic        wl_q[$];
  int          aw_cyc[$], w_cyc[$], b_cyc[$];
  int          nb = 0, stab_err = 0, npush = 0;
  logic [31:0]      exp_addr[$];
  logic [LW*32-1:0] exp_line[$];
  logic [1:0]       bresp_q[$];
  logic             acc = 1'b0;

  // Slave behaviour knobs.
  int aw_stall = 0, b_delay = 0, aw_cnt = 0, b_cnt = 0;
  bit w_toggle = 0, slave_rand = 0, w_ph = 1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin
        awready = slave_rand ? 1'($urandom_range(0, 1)) : (aw_cnt >= aw_stall);
        aw_cnt++;
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        wready = slave_rand ? 1'($urandom_range(0, 1)) : (w_toggle ? w_ph : 1'b1);
        w_ph = ~w_ph;
      end else begin wready = 0; w_ph = 1; end
      if (bready) begin
        bvalid = slave_rand ? 1'($urandom_range(0, 1)) : (b_cnt >= b_delay);
        b_cnt++;
      end else begin bvalid = 0; b_cnt = 0; end
      bresp = (nb < bresp_q.size()) ? bresp_q[nb] : 2'b00;
      bid = 4'($urandom);
    end
  end

  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wlast = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      p_awv = 0; p_wv = 0;
    end else begin
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) stab_err++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stab_err++;
      if (awvalid && awready) begin aw_q.push_back(awaddr); aw_cyc.push_back(cyc); end
      if (wvalid && wready) begin
        wd_q.push_back(wdata); wl_q.push_back(wlast); w_cyc.push_back(cyc);
      end
      if (bvalid && bready) begin nb++; b_cyc.push_back(cyc); end
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; record a push accepted at the edge into the model.
  task automatic step();
    logic a;
    @(negedge clk);
    a = wb_req && wb_ready && !rst;
    @(posedge clk); #1;
    acc = a;
    if (a) begin
      exp_addr.push_back({wb_addr[31:5], 5'b0});
      exp_line.push_back(wb_data);
      npush++;
    end
  endtask

  task automatic clear_all();
    aw_q.delete(); wd_q.delete(); wl_q.delete(); aw_cyc.delete(); w_cyc.delete();
    b_cyc.delete(); exp_addr.delete(); exp_line.delete(); bresp_q.delete();
    nb = 0; npush = 0; stab_err = 0;
    aw_stall = 0; b_delay = 0; w_toggle = 0; slave_rand = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    for (int k = nb; k < npush; k++) if (exp_addr[k][31:5] == a[31:5]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LW*32-1:0] rand_line();
    logic [LW*32-1:0] d;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (awvalid !== 0) begin errors++; $display("FAIL reset_awvalid got=%b want=0", awvalid); end
    checks++; if (wvalid !== 0) begin errors++; $display("FAIL reset_wvalid got=%b want=0", wvalid); end
    checks++; if (bready !== 0) begin errors++; $display("FAIL reset_bready got=%b want=0", bready); end
    checks++; if (wb_ready !== 1) begin errors++; $display("FAIL reset_wb_ready got=%b want=1", wb_ready); end
    checks++; if (wb_empty !== 1) begin errors++; $display("FAIL reset_wb_empty got=%b want=1", wb_empty); end
    checks++; if (wb_err !== 0) begin errors++; $display("FAIL reset_wb_err got=%b want=0", wb_err); end
    rst = 0;
    repeat (3) step();
    checks++; if (awvalid !== 0) begin errors++; $display("FAIL idle_awvalid got=%b want=0", awvalid); end
    checks++; if (q_hit !== 0) begin errors++; $display("FAIL reset_q_hit got=%b want=0", q_hit); end
  endtask

  task automatic test_single_line();
    int t, n;
    logic [LW*32-1:0] d;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = i;
    clear_all();
    wb_req = 1; wb_addr = 32'h0000_1040; wb_data = d; t = cyc;
    step(); wb_req = 0;
    checks++; if (acc !== 1) begin errors++; $display("FAIL single_push got=%b want=1", acc); end
    checks++; if (awvalid !== 0) begin errors++; $display("FAIL single_aw_early got=%b want=0", awvalid); end
    step();
    checks++; if (awvalid !== 1) begin errors++; $display("FAIL single_aw_t2 got=%b want=1", awvalid); end
    checks++; if (awaddr !== 32'h1040) begin errors++; $display("FAIL single_awaddr got=%h want=00001040", awaddr); end
    checks++; if ({awlen, awsize, awburst, awlock, awcache, awprot, awid} !== {8'd7, 3'b010, 2'b01, 2'b0, 4'h0, 3'b0, 4'd1}) begin
      errors++; $display("FAIL single_aw_fields got=%h/%h/%h/%h/%h/%h/%h want=7/2/1/0/0/0/1",
                        awlen, awsize, awburst, awlock, awcache, awprot, awid);
    end
    n = 0;
    while (!wb_empty && n < 40) begin
      if (wvalid) begin
        checks++; if ({wstrb, wid} !== {4'hf, 4'd1}) begin errors++; $display("FAIL single_wfields got=%h/%h want=f/1", wstrb, wid); end
      end
      step(); n++;
    end
    checks++; if (n >= 40) begin errors++; $display("FAIL single_timeout got=%0d want<40", n); end
    checks++; if (wd_q.size() !== 8 || aw_q.size() !== 1) begin
      errors++; $display("FAIL single_counts got=%0d/%0d want=8/1", wd_q.size(), aw_q.size());
    end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== 32'(i) || wl_q[i] !== (i == 7)) begin
        errors++; $display("FAIL single_beat%0d got=%h/%b want=%h/%b", i, wd_q[i], wl_q[i], i, i == 7);
      end
    end
    checks++; if (w_cyc.size() == 8 && (w_cyc[0] !== t+3 || w_cyc[7] !== t+10)) begin
      errors++; $display("FAIL single_wtiming got=%0d..%0d want=%0d..%0d", w_cyc[0]-t, w_cyc[7]-t, 3, 10);
    end
    checks++; if (b_cyc.size() !== 1 || b_cyc[0] !== t+11) begin
      errors++; $display("FAIL single_btiming got=%0d want=%0d", b_cyc.size() ? b_cyc[0]-t : -1, 11);
    end
  endtask

  task automatic test_backpressure();
    int t, n;
    clear_all();
    aw_stall = 3; w_toggle = 1; b_delay = 5;
    wb_req = 1; wb_addr = $urandom; wb_data = rand_line(); t = cyc;
    step(); wb_req = 0;
    n = 0;
    while (!wb_empty && n < 80) begin step(); n++; end
    checks++; if (n >= 80) begin errors++; $display("FAIL bp_timeout got=%0d want<80", n); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stab_err); end
    checks++; if (aw_q.size() !== 1 || aw_q[0] !== exp_addr[0] || aw_cyc[0] !== t+5) begin
      errors++; $display("FAIL bp_aw got=%h@%0d want=%h@%0d", aw_q[0], aw_cyc[0]-t, exp_addr[0], 5);
    end
    checks++; if (wd_q.size() !== 8) begin errors++; $display("FAIL bp_wcount got=%0d want=8", wd_q.size()); end
    for (int i = 0; i < wd_q.size(); i++) begin
      checks++; if (wd_q[i] !== exp_line[0][32*i +: 32]) begin
        errors++; $display("FAIL bp_beat%0d got=%h want=%h", i, wd_q[i], exp_line[0][32*i +: 32]);
      end
    end
    checks++; if (w_cyc.size() == 8 && w_cyc[7] - w_cyc[0] !== 14) begin
      errors++; $display("FAIL bp_wspan got=%0d want=14", w_cyc[7] - w_cyc[0]);
    end
    checks++; if (b_cyc.size() !== 1 || b_cyc[0] - w_cyc[7] !== 6) begin
      errors++; $display("FAIL bp_b got=%0d want=1 pop 6 cycles after wlast", b_cyc.size());
    end
  endtask

  task automatic test_full_fifo();
    int n, cacc;
    logic [31:0] want[3];
    want[0] = 32'h100; want[1] = 32'h200; want[2] = 32'h300;
    clear_all();
    wb_req = 1; wb_addr = want[0]; wb_data = rand_line();
    step();
    wb_addr = want[1]; wb_data = rand_line();
    step();
    checks++; if (acc !== 1 || npush !== 2) begin errors++; $display("FAIL full_ab got=%0d want=2", npush); end
    wb_addr = want[2]; wb_data = rand_line();
    n = 0; cacc = -1;
    while (n < 40) begin
      checks++; if (wb_ready !== (nb != 0)) begin
        errors++; $display("FAIL full_ready got=%b want=%b", wb_ready, nb != 0);
      end
      step(); n++;
      if (acc) begin cacc = cyc - 1; break; end
    end
    wb_req = 0;
    checks++; if (b_cyc.size() < 1 || cacc !== b_cyc[0] + 1) begin
      errors++; $display("FAIL full_c_accept got=%0d want=%0d", cacc, b_cyc.size() ? b_cyc[0] + 1 : -1);
    end
    n = 0;
    while (!wb_empty && n < 80) begin step(); n++; end
    checks++; if (aw_q.size() !== 3 || wd_q.size() !== 24) begin
      errors++; $display("FAIL full_counts got=%0d/%0d want=3/24", aw_q.size(), wd_q.size());
    end
    for (int k = 0; k < aw_q.size() && k < 3; k++) begin
      checks++; if (aw_q[k] !== want[k] || wd_q[8*k+3] !== exp_line[k][96 +: 32]) begin
        errors++; $display("FAIL full_order%0d got=%h want=%h", k, aw_q[k], want[k]);
      end
    end
  endtask

  task automatic test_query();
    int n;
    clear_all();
    b_delay = 2;
    wb_req = 1; wb_addr = 32'h1040; wb_data = rand_line(); q_addr = 32'h1040;
    #1;
    checks++; if (q_hit !== 0) begin errors++; $display("FAIL q_push_cycle got=%b want=0", q_hit); end
    step(); wb_req = 0; q_addr = 32'h1044; #1;
    checks++; if (q_hit !== 1) begin errors++; $display("FAIL q_next_cycle got=%b want=1", q_hit); end
    n = 0;
    while (!wvalid && n < 20) begin step(); n++; end
    #1;
    checks++; if (!wvalid || q_hit !== 1) begin errors++; $display("FAIL q_in_w got=%b/%b want=1/1", wvalid, q_hit); end
    q_addr = 32'h2040; #1;
    checks++; if (q_hit !== 0) begin errors++; $display("FAIL q_other_line got=%b want=0", q_hit); end
    q_addr = 32'h105c;
    n = 0;
    while (!bready && n < 20) begin step(); n++; end
    #1;
    checks++; if (!bready || q_hit !== 1) begin errors++; $display("FAIL q_in_b got=%b/%b want=1/1", bready, q_hit); end
    n = 0;
    while (nb == 0 && n < 20) begin step(); n++; end
    #1;
    checks++; if (nb !== 1 || q_hit !== 0) begin errors++; $display("FAIL q_after_b got=%0d/%b want=1/0", nb, q_hit); end
    n = 0;
    while (!wb_empty && n < 20) begin step(); n++; end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_all();
    wb_req = 1; wb_addr = 32'h5000; wb_data = rand_line();
    step();
    wb_addr = 32'h5004; wb_data = rand_line();
    step(); wb_req = 0;
    n = 0;
    while (!wb_empty && n < 60) begin step(); n++; end
    checks++; if (aw_q.size() !== 2 || b_cyc.size() !== 2) begin
      errors++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", aw_q.size(), b_cyc.size());
    end
    checks++; if (aw_cyc.size() == 2 && aw_cyc[1] - b_cyc[0] !== 2) begin
      errors++; $display("FAIL b2b_gap got=%0d want=2", aw_cyc[1] - b_cyc[0]);
    end
    checks++; if (aw_q[1] !== 32'h5000 || wd_q[8] !== exp_line[1][31:0] || wd_q[0] !== exp_line[0][31:0]) begin
      errors++; $display("FAIL b2b_nomerge got=%h/%h want=00005000/%h", aw_q[1], wd_q[8], exp_line[1][31:0]);
    end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] pool[4];
    logic [31:0] qa;
    pool[0] = 32'h1000; pool[1] = 32'h2000; pool[2] = 32'h3000; pool[3] = 32'h1020;
    clear_all();
    slave_rand = 1;
    for (int c = 0; c < 300; c++) begin
      checks++; if (wb_ready !== ((npush - nb) != DEPTH) || wb_empty !== (npush == nb)) begin
        errors++; $display("FAIL rnd_status c%0d got=%b/%b want=%b/%b", c, wb_ready, wb_empty,
                           (npush - nb) != DEPTH, npush == nb);
      end
      qa = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
      q_addr = qa; #1;
      checks++; if (q_hit !== model_hit(qa)) begin
        errors++; $display("FAIL rnd_qhit c%0d got=%b want=%b", c, q_hit, model_hit(qa));
      end
      if (acc) wb_req = 0;
      if (!wb_req && $urandom_range(0, 2) == 0) begin
        wb_req = 1; wb_addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
        wb_data = rand_line();
      end
      step();
    end
    wb_req = 0;
    n = 0;
    while (!wb_empty && n < 400) begin step(); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL rnd_drain got=%0d want<400", n); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL rnd_stable got=%0d want=0", stab_err); end
    checks++; if (aw_q.size() !== npush || wd_q.size() !== 8*npush) begin
      errors++; $display("FAIL rnd_counts got=%0d/%0d want=%0d/%0d", aw_q.size(), wd_q.size(), npush, 8*npush);
    end
    for (int k = 0; k < aw_q.size() && k < npush; k++) begin
      checks++; if (aw_q[k] !== exp_addr[k]) begin errors++; $display("FAIL rnd_addr%0d got=%h want=%h", k, aw_q[k], exp_addr[k]); end
    end
    for (int i = 0; i < wd_q.size() && i < 8*npush; i++) begin
      checks++; if (wd_q[i] !== exp_line[i/8][32*(i%8) +: 32] || wl_q[i] !== (i%8 == 7)) begin
        errors++; $display("FAIL rnd_beat%0d got=%h/%b want=%h/%b", i, wd_q[i], wl_q[i],
                           exp_line[i/8][32*(i%8) +: 32], i%8 == 7);
      end
    end
  endtask

  task automatic test_error();
    int n;
    clear_all();
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    wb_req = 1; wb_addr = 32'h7000; wb_data = rand_line();
    step();
    wb_addr = 32'h8000; wb_data = rand_line();
    step(); wb_req = 0;
    n = 0;
    while (!wb_empty && n < 60) begin
      checks++; if (wb_err !== (nb >= 1)) begin errors++; $display("FAIL err_flag nb%0d got=%b want=%b", nb, wb_err, nb >= 1); end
      step(); n++;
    end
    checks++; if (nb !== 2 || wb_err !== 1) begin errors++; $display("FAIL err_end got=%0d/%b want=2/1", nb, wb_err); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_all();
    wb_req = 1; wb_addr = 32'h9000; wb_data = rand_line();
    step();
    wb_addr = 32'hA000; wb_data = rand_line();
    step(); wb_req = 0;
    n = 0;
    while (wd_q.size() < 3 && n < 30) begin step(); n++; end
    checks++; if (wvalid !== 1 || wd_q.size() !== 3) begin errors++; $display("FAIL rm_pre got=%b/%0d want=1/3", wvalid, wd_q.size()); end
    rst = 1; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin
      errors++; $display("FAIL rm_drop got=%b%b%b want=000", awvalid, wvalid, bready);
    end
    checks++; if (wb_empty !== 1 || wb_ready !== 1 || wb_err !== 0) begin
      errors++; $display("FAIL rm_status got=%b/%b/%b want=1/1/0", wb_empty, wb_ready, wb_err);
    end
    q_addr = 32'hA000; #1;
    checks++; if (q_hit !== 0) begin errors++; $display("FAIL rm_qhit got=%b want=0", q_hit); end
    step(); rst = 0;
    clear_all();
    repeat (20) step();
    checks++; if (aw_q.size() !== 0 || awvalid !== 0) begin
      errors++; $display("FAIL rm_quiet got=%0d/%b want=0/0", aw_q.size(), awvalid);
    end
    wb_req = 1; wb_addr = 32'hB000; wb_data = rand_line();
    step(); wb_req = 0;
    n = 0;
    while (!wb_empty && n < 40) begin step(); n++; end
    checks++; if (aw_q.size() !== 1 || aw_q[0] !== 32'hB000 || wd_q.size() !== 8 || wd_q[7] !== exp_line[0][255:224]) begin
      errors++; $display("FAIL rm_after got=%0d/%h want=1/0000b000", aw_q.size(), aw_q.size() ? aw_q[0] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_full_fifo();
    test_query();
    test_back_to_back();
    test_random();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
